// File: rtl/ternary_pkg.sv
// ---------------------------------------------------------------------------
// ternary_pkg
// Shared constants and types for the ternary load/multiply datapath and its
// sequencer (ternary_seq_ctrl, ternary_wrap_ctr, loader, multiplier).
// No ports; import with "import ternary_pkg::*;".
// ---------------------------------------------------------------------------
package ternary_pkg;

  // Datapath geometry
  localparam int MAX_IN_LEN  = 14;  // ternary inputs per vector (weight row width)
  localparam int MAX_OUT_LEN = 7;   // output rows per frame
  localparam int LOAD_BEATS  = 14;  // 16-bit beats per full weight load
  localparam int MULT_LAT    = 1;   // accepted compute beat -> mult result latency
  localparam int TIMEOUT     = 255; // idle cycles tolerated mid-load (timeout build only)

  localparam int ROW_W = 3;  // row index width
  localparam int IDX_W = 4;  // load slot index width
  localparam int TO_W  = 8;  // load idle counter width

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Two-bit ternary weight encoding shared with the loader and multiplier
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;

endpackage : ternary_pkg

// File: rtl/ternary_wrap_ctr.sv
// ---------------------------------------------------------------------------
// ternary_wrap_ctr
// Wrapping up-counter 0..MAX-1 with synchronous clear (clear wins over inc).
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  synchronous active-low reset
//   inc_i  in  1  advance by one, wrapping MAX-1 -> 0
//   clr_i  in  1  force to 0 on next edge
//   val_o  out W  current count
//   last_o out 1  count == MAX-1
// ---------------------------------------------------------------------------
module ternary_wrap_ctr #(
  parameter int MAX = 7,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] val_o,
  output logic         last_o
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] val_q, val_d;

  assign last_o = (val_q == LAST);
  assign val_o  = val_q;

  // NOTE: default assignment first so no path leaves val_d unassigned (no latch).
  always_comb begin
    val_d = val_q;
    if (clr_i)      val_d = '0;
    else if (inc_i) val_d = last_o ? '0 : val_q + 1'b1;
  end

  // NOTE: reset is sampled on the clock edge only (synchronous), and state uses <=.
  always_ff @(posedge clk) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

endmodule : ternary_wrap_ctr

// File: rtl/ternary_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ternary_seq_ctrl
// Handshaked sequencer for the ternary load/multiply datapath. Steers
// LOAD_BEATS beats into the weight loader, then streams vectors through the
// multiplier, issuing rows 0..MAX_OUT_LEN-1 per frame.
// Optional build macro: TERNARY_SEQ_TIMEOUT_EN (load idle timeout + err flag).
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  synchronous active-low reset
//   start      in  1  pulse: begin weight load from IDLE
//   reload     in  1  level: return to LOAD at next frame boundary
//   in_valid   in  1  upstream beat valid
//   in_ready   out 1  beat accepted when in_valid & in_ready
//   load_en    out 1  loader enable (LOAD state)
//   load_idx   out 4  loader slot for current beat
//   mult_en    out 1  multiplier enable on accepted RUN beats
//   row        out 3  output row of current mult beat
//   out_valid  out 1  mult result valid, MULT_LAT after accepted RUN beat
//   frame_done out 1  pulse with the last-row result
//   busy       out 1  state != IDLE
//   err        out 1  sticky load timeout (0 without the macro)
// ---------------------------------------------------------------------------
module ternary_seq_ctrl
  import ternary_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             reload,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_en,
  output logic [IDX_W-1:0] load_idx,
  output logic             mult_en,
  output logic [ROW_W-1:0] row,
  output logic             out_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             err
);

  state_e state_q, state_d;

  logic in_load, in_run, accept;
  logic load_last, row_last;
  logic reload_go, timeout_hit, load_clr;

  assign in_load  = (state_q == LOAD);
  assign in_run   = (state_q == RUN);
  assign in_ready = in_load | in_run;
  assign accept   = in_valid & in_ready;
  assign load_en  = in_load;
  assign mult_en  = in_run & accept;
  assign busy     = (state_q != IDLE);

  // Frame boundary: an idle cycle at row 0, or the cycle the last row is taken.
  // A partially streamed frame is never cut short.
  assign reload_go = in_run & reload &
                     ((row == '0 && !accept) || (accept && row_last));

  assign load_clr = (state_q == IDLE) | timeout_hit | reload_go;

  ternary_wrap_ctr #(.MAX(LOAD_BEATS), .W(IDX_W)) u_load_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (in_load & accept),
    .clr_i  (load_clr),
    .val_o  (load_idx),
    .last_o (load_last)
  );

  ternary_wrap_ctr #(.MAX(MAX_OUT_LEN), .W(ROW_W)) u_row_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (mult_en),
    .clr_i  (!in_run),
    .val_o  (row),
    .last_o (row_last)
  );

`ifdef TERNARY_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] idle_q, idle_d;
  logic            err_q, err_d;

  // Fires on the TIMEOUT-th consecutive LOAD cycle without an accepted beat.
  assign timeout_hit = in_load & !accept & (idle_q == TO_W'(TIMEOUT - 1));
  assign err         = err_q;

  always_comb begin
    idle_d = (in_load && !accept) ? idle_q + 1'b1 : '0;
    err_d  = err_q;
    if (state_q == IDLE && start) err_d = 1'b0;
    if (timeout_hit)              err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (timeout_hit)            state_d = IDLE;
               else if (accept && load_last) state_d = RUN;
      RUN:     if (reload_go) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Result-valid pipeline: one stage per cycle of multiplier latency. Beats
  // already in flight drain even after the FSM has left RUN.
  logic [MULT_LAT-1:0] vld_sr_q, done_sr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vld_sr_q  <= '0;
      done_sr_q <= '0;
    end else begin
      state_q      <= state_d;
      vld_sr_q[0]  <= mult_en;
      done_sr_q[0] <= mult_en & row_last;
      for (int i = 1; i < MULT_LAT; i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        done_sr_q[i] <= done_sr_q[i-1];
      end
    end
  end

  assign out_valid  = vld_sr_q[MULT_LAT-1];
  assign frame_done = done_sr_q[MULT_LAT-1];

endmodule : ternary_seq_ctrl

// File: tb/tb_ternary_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ternary_seq_ctrl
// Directed bench for ternary_seq_ctrl. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_ternary_seq_ctrl;

  localparam int LOAD_BEATS = 14;
  localparam int ROWS       = 7;

  logic       clk = 1'b0;
  logic       rst_n, start, reload, in_valid;
  logic       in_ready, load_en, mult_en, out_valid, frame_done, busy, err;
  logic [3:0] load_idx;
  logic [2:0] row;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ternary_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .reload     (reload),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load_en    (load_en),
    .load_idx   (load_idx),
    .mult_en    (mult_en),
    .row        (row),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err)
  );

  // Drives LOAD_BEATS back-to-back beats (state must be LOAD on the first),
  // checks slot order, then checks that RUN is entered at row 0.
  task automatic load_frame(input string tag);
    for (int i = 0; i < LOAD_BEATS; i++) begin
      @(negedge clk); start = 0; reload = 0; in_valid = 1; #1;
      n_total++;
      if ({load_en, in_ready, load_idx} !== {2'b11, 4'(i)})
        $display("FAIL %s load beat %0d: load_en/in_ready/idx=%b/%b/%0d want 1/1/%0d",
                 tag, i, load_en, in_ready, load_idx, i);
      else n_pass++;
    end
    @(negedge clk); in_valid = 0; #1;
    n_total++;
    if ({load_en, in_ready, busy, row} !== {3'b011, 3'd0})
      $display("FAIL %s enter RUN: load_en/in_ready/busy/row=%b/%b/%b/%0d want 0/1/1/0",
               tag, load_en, in_ready, busy, row);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; reload = 0; in_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({busy, in_ready, load_en, mult_en, out_valid, frame_done, err, load_idx, row} !== 14'b0)
      $display("FAIL reset state: busy/rdy/ld/mult/ov/fd/err=%b%b%b%b%b%b%b idx=%0d row=%0d want all 0",
               busy, in_ready, load_en, mult_en, out_valid, frame_done, err, load_idx, row);
    else n_pass++;
  endtask

  task automatic test_load_back_to_back();
    @(negedge clk); rst_n = 1; start = 1; #1;
    n_total++;
    if ({busy, in_ready, load_en} !== 3'b000)
      $display("FAIL start cycle: busy/in_ready/load_en=%b/%b/%b want 0/0/0", busy, in_ready, load_en);
    else n_pass++;
    load_frame("b2b");
  endtask

  task automatic test_run_gaps();
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk); in_valid = 1; #1;
      n_total++;
      if ({mult_en, row, out_valid, frame_done} !== {1'b1, 3'(r), 2'b00})
        $display("FAIL gap beat row %0d: mult_en/row/ov/fd=%b/%0d/%b/%b want 1/%0d/0/0",
                 r, mult_en, row, out_valid, frame_done, r);
      else n_pass++;
      @(negedge clk); in_valid = 0; #1;
      n_total++;
      if ({mult_en, out_valid, frame_done, row} !== {2'b01, 1'(r == ROWS - 1), 3'((r + 1) % ROWS)})
        $display("FAIL gap result row %0d: mult_en/ov/fd/row=%b/%b/%b/%0d want 0/1/%0d/%0d",
                 r, mult_en, out_valid, frame_done, row, (r == ROWS - 1), (r + 1) % ROWS);
      else n_pass++;
    end
  endtask

  task automatic test_reload();
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk); in_valid = 1; reload = (r >= 3); #1;
      n_total++;
      if ({mult_en, in_ready, row, out_valid} !== {2'b11, 3'(r), 1'(r > 0)})
        $display("FAIL reload beat row %0d: mult_en/in_ready/row/ov=%b/%b/%0d/%b want 1/1/%0d/%0d",
                 r, mult_en, in_ready, row, out_valid, r, (r > 0));
      else n_pass++;
    end
    @(negedge clk); in_valid = 0; reload = 0; #1;
    n_total++;
    if ({load_en, in_ready, load_idx, out_valid, frame_done} !== {2'b11, 4'd0, 2'b11})
      $display("FAIL reload to LOAD: load_en/in_ready/idx/ov/fd=%b/%b/%0d/%b/%b want 1/1/0/1/1",
               load_en, in_ready, load_idx, out_valid, frame_done);
    else n_pass++;
    load_frame("reload");
    // Reload on an idle row-0 cycle leaves RUN immediately.
    @(negedge clk); reload = 1; #1;
    n_total++;
    if ({load_en, in_ready} !== 2'b01)
      $display("FAIL idle reload cycle: load_en/in_ready=%b/%b want 0/1", load_en, in_ready);
    else n_pass++;
    @(negedge clk); reload = 0; #1;
    n_total++;
    if ({load_en, load_idx} !== {1'b1, 4'd0})
      $display("FAIL idle reload result: load_en/idx=%b/%0d want 1/0", load_en, load_idx);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); in_valid = 1;
    end
    @(negedge clk); rst_n = 0; #1;
    n_total++;
    if (load_idx !== 4'd9)
      $display("FAIL beat 9 slot: load_idx=%0d want 9", load_idx);
    else n_pass++;
    @(negedge clk); rst_n = 1; #1;
    n_total++;
    if ({busy, in_ready, load_en, load_idx} !== 7'b0)
      $display("FAIL after mid-load reset: busy/in_ready/load_en/idx=%b/%b/%b/%0d want 0/0/0/0",
               busy, in_ready, load_en, load_idx);
    else n_pass++;
    @(negedge clk); in_valid = 0; start = 1;
    load_frame("restart");
  endtask

  task automatic test_ignored();
    @(negedge clk); start = 1; #1;
    @(negedge clk); start = 0; #1;
    n_total++;
    if ({busy, load_en, in_ready, row, load_idx} !== {3'b101, 3'd0, 4'd0})
      $display("FAIL start in RUN: busy/load_en/in_ready/row/idx=%b/%b/%b/%0d/%0d want 1/0/1/0/0",
               busy, load_en, in_ready, row, load_idx);
    else n_pass++;
    @(negedge clk); start = 1; in_valid = 1; #1;
    n_total++;
    if ({mult_en, row} !== {1'b1, 3'd0})
      $display("FAIL start with RUN beat: mult_en/row=%b/%0d want 1/0", mult_en, row);
    else n_pass++;
    @(negedge clk); start = 0; in_valid = 0; #1;
    n_total++;
    if ({row, load_en, out_valid} !== {3'd1, 2'b01})
      $display("FAIL after start+beat: row/load_en/ov=%0d/%b/%b want 1/0/1", row, load_en, out_valid);
    else n_pass++;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1; in_valid = 1; #1;
    n_total++;
    if ({in_ready, load_en, mult_en} !== 3'b000)
      $display("FAIL in_valid in IDLE: in_ready/load_en/mult_en=%b/%b/%b want 0/0/0",
               in_ready, load_en, mult_en);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if ({busy, load_idx, row, out_valid} !== 9'b0)
      $display("FAIL IDLE hold: busy/idx/row/ov=%b/%0d/%0d/%b want 0/0/0/0", busy, load_idx, row, out_valid);
    else n_pass++;
    in_valid = 0;
  endtask

  task automatic test_timeout();
    int n;
    @(negedge clk); start = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); start = 0; in_valid = 1; #1;
      n_total++;
      if (load_idx !== 4'(i))
        $display("FAIL timeout pre-beat %0d: load_idx=%0d want %0d", i, load_idx, i);
      else n_pass++;
    end
    @(negedge clk); in_valid = 0; #1;
    n = 0;
    while (load_en && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
`ifdef TERNARY_SEQ_TIMEOUT_EN
    n_total++;
    if (n !== 255)
      $display("FAIL timeout idle cycles: got %0d want 255", n);
    else n_pass++;
    n_total++;
    if ({busy, err, load_idx} !== {2'b01, 4'd0})
      $display("FAIL timeout result: busy/err/idx=%b/%b/%0d want 0/1/0", busy, err, load_idx);
    else n_pass++;
    @(negedge clk); start = 1; #1;
    @(negedge clk); start = 0; #1;
    n_total++;
    if ({err, load_en, load_idx} !== {2'b01, 4'd0})
      $display("FAIL err clear on start: err/load_en/idx=%b/%b/%0d want 0/1/0", err, load_en, load_idx);
    else n_pass++;
`else
    n_total++;
    if (n !== 300)
      $display("FAIL no-timeout hold cycles: got %0d want 300", n);
    else n_pass++;
    n_total++;
    if ({busy, err, load_idx} !== {2'b10, 4'd6})
      $display("FAIL no-timeout state: busy/err/idx=%b/%b/%0d want 1/0/6", busy, err, load_idx);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_load_back_to_back();
    test_run_gaps();
    test_reload();
    test_reset_mid_load();
    test_ignored();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ternary_seq_ctrl
